multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Moore control state machine that sequences a multi-cycle version of the CPU datapath. It shares one unified memory port between instruction fetch and data access, with a req/ready handshake. It drives the PC, IR, register-file, ALU-source and writeback mux selects for the supported ISA subset: R_TYPE (ADDU/SUB/JR/SYSCALL), LW, SW, BEQ, JUMP, JAL, LUI, ORI, ADDI, ADDIU. It sits between the instruction register's opcode/funct fields and the datapath enables; it holds no data-path state of its own except a retire counter.

Parameters:
MEM_TIMEOUT, 255, cycles a memory state may wait for mem_ready before a bus error (used only with the optional feature).
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory has completed the current read/write this cycle
mem_read  out  1  memory read request (level, held until ready)
mem_write  out  1  memory write request (level, held until ready)
i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  load IR from memory data
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU Zero (BEQ)
pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address, 11 register A (JR)
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 immediate-logic (LUI/ORI)
reg_write  out  1  register-file write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
halted  out  1  machine in HALT
bus_error  out  1  memory timeout occurred (optional feature; tied 0 otherwise)
instr_count  out  CNT_WIDTH  instructions retired since reset
state_dbg  out  4  current state encoding

Behaviour:
- States: IDLE(0), FETCH(1), DECODE(2), MEM_ADDR(3), MEM_RD(4), MEM_WB(5), MEM_WR(6), R_EXEC(7), R_WB(8), BRANCH(9), JUMP(10), JAL(11), JR(12), IMM_EXEC(13), IMM_WB(14), HALT(15).
- Reset: state <= IDLE, instr_count <= 0. In IDLE all control outputs are 0. The next edge always moves IDLE->FETCH. Reset wins over everything, including mid-handshake: mem_read/mem_write drop on the cycle after reset is sampled.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are 1 only in a cycle with mem_ready=1; that cycle also moves to DECODE. Otherwise the state stays in FETCH with the request held.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - LW/SW -> MEM_ADDR
  - R_TYPE -> JR if funct=001000; HALT if funct=001100; else R_EXEC
  - BEQ -> BRANCH
  - JUMP -> JUMP; JAL -> JAL
  - LUI/ORI/ADDI/ADDIU -> IMM_EXEC
  - any other opcode -> HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Retires, -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Retires on mem_ready, -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires.
- JUMP: pc_write=1, pc_source=10. Retires.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. The PC value written is the already-incremented PC+4. Retires.
- JR: pc_write=1, pc_source=11. Retires.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op = 11 for LUI/ORI, 00 for ADDI/ADDIU. Then IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Retires.
- HALT: all enables 0, halted=1. Leaves only on reset. Entry does not count as a retire.
- Latency with mem_ready already high: BEQ/J/JAL/JR 3 cycles, R/SW/imm 4, LW 5. Each wait cycle adds 1.
- instr_count increments by 1 on the final-state edge of each retired instruction and wraps modulo 2^CNT_WIDTH.
- mem_read and mem_write are never both 1.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
- MCTRL_MEM_TIMEOUT_EN defined: a wait counter clears on entry to FETCH/MEM_RD/MEM_WR and counts each cycle without mem_ready. When it reaches MEM_TIMEOUT, the FSM goes to HALT with bus_error=1, sticky until reset.
- Not defined: no counter; bus_error is tied 0 and the FSM waits indefinitely.

Test Plan:
- Reset held 3 cycles, release -> IDLE one cycle with all outputs 0, then FETCH with mem_read=1; instr_count=0.
- ADDU (opcode 000000, funct 100001), mem_ready tied 1 -> states 1,2,7,8. reg_write=1 with reg_dst=01 in the 4th cycle; instr_count=1.
- LW (100011), mem_ready low 3 cycles in MEM_RD -> mem_read held with i_or_d=1 for 4 cycles. MEM_WB gives mem_to_reg=01; total 8 cycles.
- JAL (000011) -> pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10 in cycle 3; next state FETCH.
- SYSCALL (funct 001100), then opcode 111111 after a reset -> HALT, halted=1, stays there for 20 cycles; instr_count unchanged.
- With MCTRL_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_error=1 and HALT after 4 wait cycles. Reset asserted mid-wait clears both.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Moore control FSM sequencing a multi-cycle CPU datapath with a
//             unified req/ready memory port. Optional macro:
//             MCTRL_MEM_TIMEOUT_EN (memory wait timeout -> HALT + bus_error)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 halted,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [3:0]           state_dbg
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_FETCH    = 4'd1;
    localparam logic [3:0] c_DECODE   = 4'd2;
    localparam logic [3:0] c_MEM_ADDR = 4'd3;
    localparam logic [3:0] c_MEM_RD   = 4'd4;
    localparam logic [3:0] c_MEM_WB   = 4'd5;
    localparam logic [3:0] c_MEM_WR   = 4'd6;
    localparam logic [3:0] c_R_EXEC   = 4'd7;
    localparam logic [3:0] c_R_WB     = 4'd8;
    localparam logic [3:0] c_BRANCH   = 4'd9;
    localparam logic [3:0] c_JUMP     = 4'd10;
    localparam logic [3:0] c_JAL      = 4'd11;
    localparam logic [3:0] c_JR       = 4'd12;
    localparam logic [3:0] c_IMM_EXEC = 4'd13;
    localparam logic [3:0] c_IMM_WB   = 4'd14;
    localparam logic [3:0] c_HALT     = 4'd15;

    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_J      = 6'h02;
    localparam logic [5:0] c_OP_JAL    = 6'h03;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_ADDI   = 6'h08;
    localparam logic [5:0] c_OP_ADDIU  = 6'h09;
    localparam logic [5:0] c_OP_ORI    = 6'h0D;
    localparam logic [5:0] c_OP_LUI    = 6'h0F;
    localparam logic [5:0] c_OP_LW     = 6'h23;
    localparam logic [5:0] c_OP_SW     = 6'h2B;
    localparam logic [5:0] c_FN_JR     = 6'b001000;
    localparam logic [5:0] c_FN_SYSCALL = 6'b001100;

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic                 w_retire;
    logic                 w_timeout;
    logic [CNT_WIDTH-1:0] r_count;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            c_IDLE:   w_next = c_FETCH;
            c_FETCH:  if (mem_ready) w_next = c_DECODE;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEM_ADDR;
                    c_OP_RTYPE: begin
                        if (funct == c_FN_JR)
                            w_next = c_JR;
                        else if (funct == c_FN_SYSCALL)
                            w_next = c_HALT;
                        else
                            w_next = c_R_EXEC;
                    end
                    c_OP_BEQ: w_next = c_BRANCH;
                    c_OP_J:   w_next = c_JUMP;
                    c_OP_JAL: w_next = c_JAL;
                    c_OP_LUI, c_OP_ORI, c_OP_ADDI, c_OP_ADDIU: w_next = c_IMM_EXEC;
                    default:  w_next = c_HALT;
                endcase
            end
            c_MEM_ADDR: w_next = (opcode == c_OP_LW) ? c_MEM_RD : c_MEM_WR;
            c_MEM_RD:   if (mem_ready) w_next = c_MEM_WB;
            c_MEM_WR: begin
                if (mem_ready) begin
                    w_next   = c_FETCH;
                    w_retire = 1'b1;
                end
            end
            c_R_EXEC:   w_next = c_R_WB;
            c_IMM_EXEC: w_next = c_IMM_WB;
            c_MEM_WB, c_R_WB, c_BRANCH, c_JUMP, c_JAL, c_JR, c_IMM_WB: begin
                w_next   = c_FETCH;
                w_retire = 1'b1;
            end
            c_HALT:  w_next = c_HALT;
            default: w_next = c_IDLE;
        endcase
        // A timeout can only fire in a wait cycle, where no retire is pending.
        if (w_timeout)
            w_next = c_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + CNT_WIDTH'(1);
        end
    end

`ifdef MCTRL_MEM_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_bus_error;
    logic                w_wait_state;

    assign w_wait_state = (r_state == c_FETCH) || (r_state == c_MEM_RD) ||
                          (r_state == c_MEM_WR);
    assign w_timeout    = w_wait_state && !mem_ready &&
                          (r_wait == c_WAIT_W'(MEM_TIMEOUT - 1));

    // Counter restarts whenever a handshake completes or we are not waiting.
    always_ff @(posedge clk) begin
        if (reset || !w_wait_state || mem_ready)
            r_wait <= '0;
        else
            r_wait <= r_wait + c_WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_bus_error <= 1'b0;
        else if (w_timeout)
            r_bus_error <= 1'b1;
    end

    assign bus_error = r_bus_error;
`else
    assign w_timeout = 1'b0;
    // Constant low; the comparison only keeps MEM_TIMEOUT referenced here.
    assign bus_error = (MEM_TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        case (r_state)
            c_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            c_DECODE:   alu_src_b = 2'b11;
            c_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            c_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            c_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            c_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            c_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            c_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            c_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            c_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            c_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            c_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
            end
            c_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ((opcode == c_OP_LUI) || (opcode == c_OP_ORI)) ? 2'b11 : 2'b00;
            end
            c_IMM_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign halted      = (r_state == c_HALT);
    assign instr_count = r_count;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Self-checking bench: per-instruction cycle model vs. the FSM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int TB_CNT_W = 4;
`ifdef MCTRL_MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_JR = 6'h08, FN_SYS = 6'h0C;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       halted;
        logic       bus_error;
    } ctrl_t;

    typedef struct {
        logic                rdy;
        logic [5:0]          op;
        logic [5:0]          fn;
        logic [3:0]          st;
        ctrl_t               ctrl;
        logic [TB_CNT_W-1:0] cnt;
    } cyc_t;

    logic                clk, reset, mem_ready;
    logic [5:0]          opcode, funct;
    logic                mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0]          pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic                alu_src_a, reg_write, halted, bus_error;
    logic [TB_CNT_W-1:0] instr_count;
    logic [3:0]          state_dbg;
    ctrl_t               dut_ctrl;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .halted(halted), .bus_error(bus_error), .instr_count(instr_count),
        .state_dbg(state_dbg)
    );

    assign dut_ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                       pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                       mem_to_reg, halted, bus_error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                  checks   = 0;
    int                  failures = 0;
    cyc_t                q[$];
    logic [TB_CNT_W-1:0] m_count;
    logic                m_berr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Expected control outputs for a given architectural step.
    function automatic ctrl_t exp_ctrl(input int ph, input logic rdy, input logic [5:0] op);
        ctrl_t c = '0;
        case (ph)
            1:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
            2:  c.alu_src_b = 2'b11;
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4:  begin c.mem_read = 1; c.i_or_d = 1; end
            5:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            6:  begin c.mem_write = 1; c.i_or_d = 1; end
            7:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            8:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
            9:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            10: begin c.pc_write = 1; c.pc_source = 2'b10; end
            11: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1;
                      c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
            12: begin c.pc_write = 1; c.pc_source = 2'b11; end
            13: begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                      c.alu_op = (op == OP_LUI || op == OP_ORI) ? 2'b11 : 2'b00; end
            14: c.reg_write = 1;
            15: begin c.halted = 1; c.bus_error = m_berr; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic void push(input int ph, input logic rdy, input logic [5:0] op,
                                 input logic [5:0] fn, input logic ret);
        cyc_t c;
        c.rdy = rdy; c.op = op; c.fn = fn; c.st = 4'(ph);
        c.ctrl = exp_ctrl(ph, rdy, op);
        c.cnt = m_count;
        q.push_back(c);
        if (ret) m_count = m_count + 1'b1;
    endfunction

    // fw/mw: wait cycles in fetch / data access; o: mem_ready level elsewhere.
    function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input int fw, input int mw, input logic o);
        for (int i = 0; i < fw; i++) push(1, 1'b0, op, fn, 1'b0);
        push(1, 1'b1, op, fn, 1'b0);
        push(2, o, op, fn, 1'b0);
        case (op)
            OP_LW: begin
                push(3, o, op, fn, 1'b0);
                for (int i = 0; i < mw; i++) push(4, 1'b0, op, fn, 1'b0);
                push(4, 1'b1, op, fn, 1'b0);
                push(5, o, op, fn, 1'b1);
            end
            OP_SW: begin
                push(3, o, op, fn, 1'b0);
                for (int i = 0; i < mw; i++) push(6, 1'b0, op, fn, 1'b0);
                push(6, 1'b1, op, fn, 1'b1);
            end
            OP_R: begin
                if (fn == FN_JR) push(12, o, op, fn, 1'b1);
                else if (fn != FN_SYS) begin
                    push(7, o, op, fn, 1'b0);
                    push(8, o, op, fn, 1'b1);
                end
            end
            OP_BEQ: push(9, o, op, fn, 1'b1);
            OP_J:   push(10, o, op, fn, 1'b1);
            OP_JAL: push(11, o, op, fn, 1'b1);
            OP_LUI, OP_ORI, OP_ADDI, OP_ADDIU: begin
                push(13, o, op, fn, 1'b0);
                push(14, o, op, fn, 1'b1);
            end
            default: ;
        endcase
    endfunction

    function automatic void add_halt(input int n, input logic [5:0] op);
        for (int i = 0; i < n; i++) push(15, i[0], op, 6'h00, 1'b0);
    endfunction

    task automatic run();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy; opcode = c.op; funct = c.fn;
            @(negedge clk);
            chk("state", 32'(state_dbg), 32'(c.st));
            chk("ctrl", 32'(dut_ctrl), 32'(c.ctrl));
            chk("count", 32'(instr_count), 32'(c.cnt));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_state", 32'(state_dbg), 32'd0);
            chk("rst_ctrl", 32'(dut_ctrl), 32'd0);
            chk("rst_count", 32'(instr_count), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_count = '0; m_berr = 1'b0;
        push(0, 1'b0, 6'h00, 6'h00, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        m_count = '0; m_berr = 1'b0;
        do_reset(3);

        add_instr(OP_R, FN_ADDU, 0, 0, 1'b1);
        run();
        chk("addu_count_lit", 32'(instr_count), 32'd1);

        n = q.size();
        add_instr(OP_LW, 6'h00, 0, 3, 1'b0);
        chk("lw_cycles_lit", 32'(q.size() - n), 32'd8);
        run();

        add_instr(OP_JAL, 6'h00, 0, 0, 1'b1);
        run();
        chk("jal_next_fetch_lit", 32'(state_dbg), 32'd1);

        add_instr(OP_SW, 6'h00, 1, 1, 1'b0);
        add_instr(OP_BEQ, 6'h00, 0, 0, 1'b1);
        add_instr(OP_J, 6'h00, 0, 0, 1'b0);
        add_instr(OP_R, FN_JR, 0, 0, 1'b1);
        add_instr(OP_LUI, 6'h00, 0, 0, 1'b1);
        add_instr(OP_ORI, 6'h00, 2, 0, 1'b0);
        add_instr(OP_ADDI, 6'h00, 0, 0, 1'b1);
        add_instr(OP_ADDIU, 6'h00, 0, 0, 1'b1);
        add_instr(OP_R, FN_SUB, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) add_instr(OP_R, FN_ADDU, 0, 0, 1'b1);
        run();
        chk("wrap_count_lit", 32'(instr_count), 32'd1);

        add_instr(OP_R, FN_SYS, 0, 0, 1'b1);
        add_halt(20, OP_R);
        run();
        chk("syscall_halted_lit", 32'(halted), 32'd1);
        chk("syscall_count_lit", 32'(instr_count), 32'd1);

        do_reset(2);
        add_instr(6'h3F, 6'h00, 1, 0, 1'b0);
        add_halt(20, 6'h3F);
        run();
        chk("badop_halted_lit", 32'(halted), 32'd1);

        do_reset(2);
        add_instr(OP_R, FN_ADDU, 3, 0, 1'b1);
        push(1, 1'b0, OP_R, FN_ADDU, 1'b0);
        push(1, 1'b0, OP_R, FN_ADDU, 1'b0);
        run();
        do_reset(1);
        add_instr(OP_ADDI, 6'h00, 0, 0, 1'b0);
        run();

`ifdef MCTRL_MEM_TIMEOUT_EN
        do_reset(1);
        for (int i = 0; i < 4; i++) push(1, 1'b0, OP_R, FN_ADDU, 1'b0);
        m_berr = 1'b1;
        add_halt(3, OP_R);
        run();
        chk("timeout_berr_lit", 32'(bus_error), 32'd1);
        do_reset(1);
        push(1, 1'b0, OP_R, FN_ADDU, 1'b0);
        push(1, 1'b0, OP_R, FN_ADDU, 1'b0);
        run();
        do_reset(1);
        add_instr(OP_R, FN_ADDU, 3, 0, 1'b1);
        run();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
